// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - armable nibble-stream sequence detector controller; optional SEQ_DET_AUTO_DISARM_EN
module seq_det_ctrl #(
    parameter int SEQ_LEN = 4,
    parameter int CNT_W   = 8,
    parameter int TMO_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [2:0]       cfg_idx_i,
    input  logic [3:0]       cfg_data_i,
    input  logic             arm_i,
    input  logic             disarm_i,
    input  logic [TMO_W-1:0] timeout_i,
    input  logic             data_valid_i,
    input  logic [3:0]       data_i,
    output logic             found_o,
    output logic             timeout_o,
    output logic             busy_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] match_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam logic [2:0] LAST_PTR  = 3'(SEQ_LEN - 1);
    localparam logic [3:0] SEQ_LEN_N = 4'(SEQ_LEN);

`ifdef SEQ_DET_AUTO_DISARM_EN
    // a completed match hands control back to software, which must re-arm
    localparam state_t MATCH_STATE = IDLE;
`else
    // detection continues seamlessly after a completed match
    localparam state_t MATCH_STATE = ARMED;
`endif

    state_t           state;
    state_t           state_next;
    logic [2:0]       ptr;
    logic [2:0]       ptr_next;
    logic [TMO_W-1:0] idle;
    logic [TMO_W-1:0] idle_next;
    logic [TMO_W-1:0] idle_inc;
    logic [3:0]       pat [8];
    logic             match_evt;
    logic             tmo_evt;
    logic             cfg_write;

    // the idle counter sticks at all-ones rather than wrapping back under timeout_i
    assign idle_inc  = (&idle) ? idle : idle + 1'b1;
    assign cfg_write = cfg_valid_i && cfg_ready_o;

    // state register together with the match pointer and idle counter it owns
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            ptr   <= 3'd0;
            idle  <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            idle  <= idle_next;
        end
    end

    // next-state logic: disarm first, then per-state element and timeout handling
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        idle_next  = idle;
        match_evt  = 1'b0;
        tmo_evt    = 1'b0;
        if (disarm_i) begin
            state_next = IDLE;
            ptr_next   = 3'd0;
            idle_next  = '0;
        end else begin
            case (state)
                IDLE: begin
                    ptr_next  = 3'd0;
                    idle_next = '0;
                    if (arm_i) begin
                        state_next = ARMED;
                    end
                end
                ARMED: begin
                    idle_next = '0;
                    if (data_valid_i && (data_i == pat[0])) begin
                        if (SEQ_LEN == 1) begin
                            match_evt  = 1'b1;
                            state_next = MATCH_STATE;
                        end else begin
                            ptr_next   = 3'd1;
                            state_next = TRACK;
                        end
                    end
                end
                TRACK: begin
                    if (data_valid_i) begin
                        idle_next = '0;
                        if (data_i == pat[ptr]) begin
                            if (ptr == LAST_PTR) begin
                                match_evt  = 1'b1;
                                ptr_next   = 3'd0;
                                state_next = MATCH_STATE;
                            end else begin
                                ptr_next = ptr + 3'd1;
                            end
                        end else if (data_i == pat[0]) begin
                            ptr_next = 3'd1;
                        end else begin
                            ptr_next   = 3'd0;
                            state_next = ARMED;
                        end
                    end else if ((timeout_i != '0) && (idle_inc == timeout_i)) begin
                        tmo_evt    = 1'b1;
                        ptr_next   = 3'd0;
                        idle_next  = '0;
                        state_next = ARMED;
                    end else begin
                        idle_next = idle_inc;
                    end
                end
                default: begin
                    state_next = IDLE;
                    ptr_next   = 3'd0;
                    idle_next  = '0;
                end
            endcase
        end
    end

    // state-decoded outputs
    always_comb begin
        cfg_ready_o = (state == IDLE);
        busy_o      = (state == ARMED) || (state == TRACK);
        state_o     = state;
    end

    // pattern store; writes to slots beyond the pattern length complete but are dropped
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pat[0] <= 4'd1;
            pat[1] <= 4'd0;
            pat[2] <= 4'd2;
            pat[3] <= 4'd4;
            for (int i = 4; i < 8; i++) begin
                pat[i] <= 4'd0;
            end
        end else if (cfg_write && ({1'b0, cfg_idx_i} < SEQ_LEN_N)) begin
            pat[cfg_idx_i] <= cfg_data_i;
        end
    end

    // registered event pulses and saturating match statistics
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            found_o     <= 1'b0;
            timeout_o   <= 1'b0;
            match_cnt_o <= '0;
        end else begin
            found_o   <= match_evt;
            timeout_o <= tmo_evt;
            if (match_evt && !(&match_cnt_o)) begin
                match_cnt_o <= match_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb/tb_seq_det_ctrl.sv - randomized and directed bench for seq_det_ctrl against a queue-based reference model
module tb_seq_det_ctrl;

    localparam int SEQ_LEN = 4;
    localparam int TMO_W   = 8;
`ifdef SEQ_DET_AUTO_DISARM_EN
    localparam logic [1:0] POST_MATCH_STATE = 2'd0;
    localparam int         B2B_FOUND        = 1;
`else
    localparam logic [1:0] POST_MATCH_STATE = 2'd1;
    localparam int         B2B_FOUND        = 5;
`endif

    logic             clk        = 1'b0;
    logic             rst        = 1'b1;
    logic             cfg_valid  = 1'b0;
    logic [2:0]       cfg_idx    = 3'd0;
    logic [3:0]       cfg_data   = 4'd0;
    logic             arm        = 1'b0;
    logic             disarm     = 1'b0;
    logic [TMO_W-1:0] timeout    = '0;
    logic             data_valid = 1'b0;
    logic [3:0]       data       = 4'd0;

    logic       cfg_ready, found, tmo, busy;
    logic [1:0] state;
    logic [7:0] cnt;
    logic       cfg_ready2, found2, tmo2, busy2;
    logic [1:0] state2;
    logic [1:0] cnt2;

    int vectors = 0;
    int errors  = 0;

    seq_det_ctrl #(.SEQ_LEN(SEQ_LEN), .CNT_W(8), .TMO_W(TMO_W)) dut (
        .clk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_idx_i(cfg_idx), .cfg_data_i(cfg_data), .arm_i(arm), .disarm_i(disarm),
        .timeout_i(timeout), .data_valid_i(data_valid), .data_i(data),
        .found_o(found), .timeout_o(tmo), .busy_o(busy), .state_o(state), .match_cnt_o(cnt)
    );

    seq_det_ctrl #(.SEQ_LEN(SEQ_LEN), .CNT_W(2), .TMO_W(TMO_W)) dut2 (
        .clk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready2),
        .cfg_idx_i(cfg_idx), .cfg_data_i(cfg_data), .arm_i(arm), .disarm_i(disarm),
        .timeout_i(timeout), .data_valid_i(data_valid), .data_i(data),
        .found_o(found2), .timeout_o(tmo2), .busy_o(busy2), .state_o(state2), .match_cnt_o(cnt2)
    );

    always #5 clk = ~clk;

    // reference model: pattern, the nibbles matched so far, armed flag, gap length, totals
    logic [3:0] m_pat [8];
    logic [3:0] m_part [$];
    bit         m_on;
    int         m_idle;
    int         m_total;
    bit         m_found;
    bit         m_tmo;

    function automatic void m_reset();
        m_pat   = '{4'd1, 4'd0, 4'd2, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0};
        m_part.delete();
        m_on    = 1'b0;
        m_idle  = 0;
        m_total = 0;
        m_found = 1'b0;
        m_tmo   = 1'b0;
    endfunction

    function automatic logic [1:0] m_state();
        if (!m_on) return 2'd0;
        return (m_part.size() > 0) ? 2'd2 : 2'd1;
    endfunction

    function automatic int m_sat(input int n, input int w);
        return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
    endfunction

    function automatic void m_apply();
        m_found = 1'b0;
        m_tmo   = 1'b0;
        if (!m_on && cfg_valid && int'(cfg_idx) < SEQ_LEN) m_pat[cfg_idx] = cfg_data;
        if (disarm) begin
            m_on = 1'b0;
            m_part.delete();
            m_idle = 0;
        end else if (!m_on) begin
            m_on = arm;
        end else if (data_valid) begin
            m_idle = 0;
            if (m_pat[m_part.size()] == data) m_part.push_back(data);
            else if (m_pat[0] == data) m_part = '{data};
            else m_part.delete();
            if (m_part.size() == SEQ_LEN) begin
                m_found = 1'b1;
                m_total++;
                m_part.delete();
`ifdef SEQ_DET_AUTO_DISARM_EN
                m_on = 1'b0;
`endif
            end
        end else if (m_part.size() != 0) begin
            if (m_idle < (1 << TMO_W) - 1) m_idle++;
            if (timeout != 0 && m_idle == int'(timeout)) begin
                m_tmo = 1'b1;
                m_part.delete();
                m_idle = 0;
            end
        end
    endfunction

    task automatic step(input bit v, input logic [3:0] x, input bit a = 1'b0, input bit d = 1'b0);
        data_valid = v;
        data       = x;
        arm        = a;
        disarm     = d;
        @(posedge clk);
        m_apply();
        #1;
    endtask

    task automatic cfg_step(input logic [2:0] i, input logic [3:0] d);
        cfg_valid = 1'b1;
        cfg_idx   = i;
        cfg_data  = d;
        step(1'b0, 4'd0);
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        data_valid = 1'b0; arm = 1'b0; disarm = 1'b0; cfg_valid = 1'b0; timeout = '0;
        repeat (2) @(posedge clk);
        m_reset();
        #1;
        rst = 1'b0;
        vectors++; if (state !== 2'd0)     begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        vectors++; if (found !== 1'b0)     begin errors++; $display("FAIL reset_found got %0b want 0", found); end
        vectors++; if (tmo !== 1'b0)       begin errors++; $display("FAIL reset_timeout got %0b want 0", tmo); end
        vectors++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        vectors++; if (cnt !== 8'd0)       begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt); end
        vectors++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %0b want 1", cfg_ready); end
    endtask

    task automatic test_basic_match();
        logic [3:0] seq [4] = '{4'd1, 4'd0, 4'd2, 4'd4};
        step(1'b0, 4'd0, 1'b1);
        vectors++; if (state !== 2'd1) begin errors++; $display("FAIL arm_state got %0d want 1", state); end
        vectors++; if (busy !== 1'b1)  begin errors++; $display("FAIL arm_busy got %0b want 1", busy); end
        foreach (seq[i]) begin
            step(1'b1, seq[i]);
            vectors++;
            if (found !== m_found || state !== m_state())
                begin errors++; $display("FAIL basic_step%0d found/state got %0b/%0d want %0b/%0d", i, found, state, m_found, m_state()); end
        end
        vectors++; if (found !== 1'b1)           begin errors++; $display("FAIL basic_found got %0b want 1", found); end
        vectors++; if (cnt !== 8'd1)             begin errors++; $display("FAIL basic_cnt got %0d want 1", cnt); end
        vectors++; if (state !== POST_MATCH_STATE) begin errors++; $display("FAIL basic_post_state got %0d want %0d", state, POST_MATCH_STATE); end
        step(1'b0, 4'd0);
        vectors++; if (found !== 1'b0)           begin errors++; $display("FAIL basic_found_width got %0b want 0", found); end
    endtask

    task automatic test_restart();
        logic [3:0] seq [6] = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd2, 4'd4};
        int pulses = 0;
        step(1'b0, 4'd0, 1'b1);
        foreach (seq[i]) begin
            step(1'b1, seq[i]);
            pulses += int'(found);
            vectors++;
            if (found !== m_found || state !== m_state())
                begin errors++; $display("FAIL restart_step%0d found/state got %0b/%0d want %0b/%0d", i, found, state, m_found, m_state()); end
        end
        step(1'b0, 4'd0);
        pulses += int'(found);
        vectors++; if (pulses != 1)   begin errors++; $display("FAIL restart_pulses got %0d want 1", pulses); end
        vectors++; if (cnt !== 8'd2)  begin errors++; $display("FAIL restart_cnt got %0d want 2", cnt); end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        timeout = 8'd3;
        step(1'b0, 4'd0, 1'b1);
        step(1'b1, 4'd1);
        step(1'b1, 4'd0);
        step(1'b0, 4'd0);
        step(1'b0, 4'd0);
        vectors++; if (tmo !== 1'b0 || state !== 2'd2) begin errors++; $display("FAIL tmo_early tmo/state got %0b/%0d want 0/2", tmo, state); end
        step(1'b0, 4'd0);
        vectors++; if (tmo !== 1'b1)  begin errors++; $display("FAIL tmo_pulse got %0b want 1", tmo); end
        vectors++; if (state !== 2'd1) begin errors++; $display("FAIL tmo_state got %0d want 1", state); end
        step(1'b0, 4'd0);
        vectors++; if (tmo !== 1'b0)  begin errors++; $display("FAIL tmo_width got %0b want 0", tmo); end
        step(1'b1, 4'd2);
        pulses += int'(found);
        step(1'b1, 4'd4);
        pulses += int'(found);
        step(1'b0, 4'd0);
        pulses += int'(found);
        vectors++; if (pulses != 0)   begin errors++; $display("FAIL tmo_tail_found got %0d want 0", pulses); end
        // valid element on the cycle the counter would reach the limit wins
        pulses = 0;
        step(1'b1, 4'd1);
        step(1'b1, 4'd0);
        step(1'b0, 4'd0);
        step(1'b0, 4'd0);
        step(1'b1, 4'd2);
        pulses += int'(tmo);
        step(1'b1, 4'd4);
        pulses += int'(tmo);
        vectors++; if (pulses != 0)   begin errors++; $display("FAIL tmo_precedence got %0d want 0", pulses); end
        vectors++; if (found !== 1'b1) begin errors++; $display("FAIL tmo_precedence_found got %0b want 1", found); end
        timeout = '0;
    endtask

    task automatic test_disarm();
        int pulses = 0;
        step(1'b0, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b1, 1'b1);
        vectors++; if (state !== 2'd0) begin errors++; $display("FAIL disarm_armed got %0d want 0", state); end
        step(1'b0, 4'd0, 1'b1);
        step(1'b1, 4'd1);
        step(1'b1, 4'd0);
        vectors++; if (state !== 2'd2) begin errors++; $display("FAIL disarm_track_pre got %0d want 2", state); end
        step(1'b1, 4'd2, 1'b1, 1'b1);
        vectors++; if (state !== 2'd0) begin errors++; $display("FAIL disarm_track got %0d want 0", state); end
        step(1'b1, 4'd4);
        pulses += int'(found);
        step(1'b1, 4'd2);
        pulses += int'(found);
        step(1'b1, 4'd4);
        pulses += int'(found);
        vectors++; if (pulses != 0 || state !== 2'd0) begin errors++; $display("FAIL disarm_tail found/state got %0d/%0d want 0/0", pulses, state); end
        step(1'b0, 4'd0, 1'b1);
        step(1'b1, 4'd1);
        step(1'b1, 4'd0);
        step(1'b1, 4'd2);
        step(1'b1, 4'd4, 1'b0, 1'b1);
        vectors++; if (found !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL disarm_final found/state got %0b/%0d want 0/0", found, state); end
    endtask

    task automatic test_cfg();
        logic [3:0] pat [4] = '{4'h5, 4'h5, 4'hA, 4'h3};
        int pulses = 0;
        step(1'b0, 4'd0, 1'b0, 1'b1);
        foreach (pat[i]) begin
            vectors++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_ready_idle%0d got %0b want 1", i, cfg_ready); end
            cfg_step(3'(i), pat[i]);
        end
        cfg_step(3'd6, 4'h9);
        step(1'b0, 4'd0, 1'b1);
        foreach (pat[i]) begin
            step(1'b1, pat[i]);
            pulses += int'(found);
            repeat (2) begin
                step(1'b0, 4'd0);
                pulses += int'(found);
            end
            vectors++;
            if (found !== m_found || state !== m_state())
                begin errors++; $display("FAIL cfg_gap%0d found/state got %0b/%0d want %0b/%0d", i, found, state, m_found, m_state()); end
        end
        vectors++; if (pulses != 1) begin errors++; $display("FAIL cfg_gap_pulses got %0d want 1", pulses); end
        step(1'b0, 4'd0, 1'b1);
        vectors++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_armed got %0b want 0", cfg_ready); end
        cfg_step(3'd0, 4'hF);
        pulses = 0;
        foreach (pat[i]) begin
            step(1'b1, pat[i]);
            pulses += int'(found);
        end
        step(1'b0, 4'd0);
        pulses += int'(found);
        vectors++; if (pulses != 1) begin errors++; $display("FAIL cfg_stalled_write got %0d want 1", pulses); end
    endtask

    task automatic test_saturation();
        logic [3:0] seq [4] = '{4'd1, 4'd0, 4'd2, 4'd4};
        int pulses = 0;
        test_reset();
        step(1'b0, 4'd0, 1'b1);
        repeat (5) begin
            foreach (seq[i]) begin
                step(1'b1, seq[i]);
                pulses += int'(found);
                vectors++;
                if (found !== m_found || state !== m_state() || cnt2 !== 2'(m_sat(m_total, 2)))
                    begin errors++; $display("FAIL b2b found/state/cnt2 got %0b/%0d/%0d want %0b/%0d/%0d", found, state, cnt2, m_found, m_state(), m_sat(m_total, 2)); end
            end
        end
        step(1'b0, 4'd0);
        pulses += int'(found);
        vectors++; if (pulses != B2B_FOUND) begin errors++; $display("FAIL b2b_pulses got %0d want %0d", pulses, B2B_FOUND); end
        vectors++; if (cnt2 !== 2'(m_sat(B2B_FOUND, 2))) begin errors++; $display("FAIL b2b_cnt2 got %0d want %0d", cnt2, m_sat(B2B_FOUND, 2)); end
        vectors++; if (cnt !== 8'(B2B_FOUND)) begin errors++; $display("FAIL b2b_cnt got %0d want %0d", cnt, B2B_FOUND); end
        repeat (260) begin
            step(1'b0, 4'd0, 1'b1);
            foreach (seq[i]) step(1'b1, seq[i]);
        end
        step(1'b0, 4'd0);
        vectors++; if (cnt !== 8'hFF)  begin errors++; $display("FAIL sat_cnt8 got %0d want 255", cnt); end
        vectors++; if (cnt2 !== 2'd3)  begin errors++; $display("FAIL sat_cnt2 got %0d want 3", cnt2); end
    endtask

    task automatic test_random();
        logic [TMO_W-1:0] tmo_pick [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5};
        test_reset();
        for (int n = 0; n < 4000; n++) begin
            int r;
            if (n % 500 == 0) timeout = tmo_pick[$urandom_range(0, 4)];
            r = int'($urandom_range(0, 99));
            cfg_valid = ($urandom_range(0, 19) == 0);
            cfg_idx   = 3'($urandom_range(0, 7));
            cfg_data  = 4'($urandom_range(0, 15));
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 3) != 0) ? m_pat[$urandom_range(0, SEQ_LEN - 1)] : 4'($urandom_range(0, 15)),
                 r < 6, r >= 98);
            cfg_valid = 1'b0;
            vectors++; if (found !== m_found)     begin errors++; $display("FAIL rnd%0d found got %0b want %0b", n, found, m_found); end
            vectors++; if (tmo !== m_tmo)         begin errors++; $display("FAIL rnd%0d timeout got %0b want %0b", n, tmo, m_tmo); end
            vectors++; if (state !== m_state())   begin errors++; $display("FAIL rnd%0d state got %0d want %0d", n, state, m_state()); end
            vectors++; if (busy !== m_on)         begin errors++; $display("FAIL rnd%0d busy got %0b want %0b", n, busy, m_on); end
            vectors++; if (cfg_ready !== !m_on)   begin errors++; $display("FAIL rnd%0d cfg_ready got %0b want %0b", n, cfg_ready, !m_on); end
            vectors++; if (cnt !== 8'(m_sat(m_total, 8))) begin errors++; $display("FAIL rnd%0d cnt got %0d want %0d", n, cnt, m_sat(m_total, 8)); end
            vectors++;
            if ({found2, tmo2, busy2, state2, cfg_ready2, cnt2} !== {m_found, m_tmo, m_on, m_state(), !m_on, 2'(m_sat(m_total, 2))})
                begin errors++; $display("FAIL rnd%0d narrow_cnt_inst got %b want %b", n, {found2, tmo2, busy2, state2, cfg_ready2, cnt2}, {m_found, m_tmo, m_on, m_state(), !m_on, 2'(m_sat(m_total, 2))}); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_match();
        test_restart();
        test_timeout();
        test_disarm();
        test_cfg();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Programmable, armable controller for nibble-stream sequence detection; the match pattern is loaded at run time.
- Sequences the match datapath. Owns pattern config, arm/disarm control, inter-element timeout and match statistics.
- Sits between a software/config master and a 4-bit data stream that carries a valid strobe.

Parameters:
- SEQ_LEN, 4, pattern length in nibbles; legal range 1..8.
- CNT_W, 8, width of the saturating match counter.
- TMO_W, 8, width of the inter-element timeout counter and of the timeout_i value.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- cfg_valid_i  in  1  pattern-write request.
- cfg_ready_o  out  1  pattern write accepted. High only in IDLE.
- cfg_idx_i  in  3  pattern slot index.
- cfg_data_i  in  4  pattern nibble.
- arm_i  in  1  start detection.
- disarm_i  in  1  stop detection.
- timeout_i  in  TMO_W  maximum idle cycles between elements of one sequence; 0 disables the timeout.
- data_valid_i  in  1  stream element valid.
- data_i  in  4  stream element.
- found_o  out  1  one-cycle pulse on a complete match.
- timeout_o  out  1  one-cycle pulse when a partial match is aborted by timeout.
- busy_o  out  1  high when the state is ARMED or TRACK.
- state_o  out  2  current state: IDLE=0, ARMED=1, TRACK=2.
- match_cnt_o  out  CNT_W  total matches since reset; saturates at all-ones.

Behaviour:
- Reset values:
  - state IDLE, ptr 0, idle counter 0.
  - found_o, timeout_o, busy_o, match_cnt_o all 0.
  - Pattern slots 0..3 = 1,0,2,4; slots 4..7 = 0.
- Config:
  - A write occurs when cfg_valid_i and cfg_ready_o are both high in a cycle. pat[cfg_idx_i] <= cfg_data_i, visible the next cycle.
  - cfg_idx_i >= SEQ_LEN: write is accepted (handshake completes) and discarded.
  - Outside IDLE, cfg_ready_o=0 and requests stall; they are not dropped by the controller.
- State machine:
  - Priority order: rst_i, then disarm_i, then the rest.
  - disarm_i in any state: next state IDLE, ptr 0, idle counter 0. Disarm wins over a simultaneous arm_i or data element.
  - IDLE: arm_i -> ARMED. Data is ignored.
  - ARMED: arm_i is ignored. On data_valid_i with data_i==pat[0]:
    - SEQ_LEN==1: match event, stay ARMED.
    - otherwise: ptr=1, go to TRACK.
  - TRACK, on data_valid_i:
    - data_i==pat[ptr] and ptr==SEQ_LEN-1: match event, ptr 0, go to ARMED.
    - data_i==pat[ptr] otherwise: ptr++.
    - Mismatch with data_i==pat[0]: ptr=1, stay TRACK (restart).
    - Other mismatch: ptr 0, go to ARMED.
  - Elements with data_valid_i=0 never advance ptr.
- Timeout (active in TRACK only):
  - The idle counter clears on every accepted element and increments on each cycle with data_valid_i=0.
  - When timeout_i!=0 and the counter reaches timeout_i: timeout_o pulses the next cycle, ptr 0, go to ARMED.
  - A valid element arriving in the same cycle the counter would hit timeout_i takes precedence; no timeout fires.
  - The counter saturates at all-ones.
- Match event:
  - found_o is high exactly one cycle, the cycle after the final element is sampled (latency 1).
  - match_cnt_o increments in the same cycle found_o rises, saturating at 2^CNT_W-1.
- Back-to-back: after a complete match, the element in the very next cycle is evaluated against pat[0]. Overlapping matches are not detected.
- Pattern writes are impossible while busy, so the pattern is stable during detection.

Optional Feature:
- Macro: SEQ_DET_AUTO_DISARM_EN.
- Defined: a match event sends the FSM to IDLE instead of ARMED. found_o and the counter still update; software must re-arm.
- Undefined: the FSM returns to ARMED after a match and detection is continuous.

Test Plan:
- Reset, arm, then stream 1,0,2,4 on consecutive cycles -> found_o=1 exactly in the cycle after the 4 is sampled; match_cnt_o=1; state_o=1.
- Stream 1,0,1,0,2,4 -> the mismatch on the third element restarts at ptr=1; exactly one found_o; match_cnt_o=1.
- timeout_i=3, stream 1,0, then 3 cycles with valid=0 -> timeout_o pulses once; state_o=1. Following 2,4 gives no found_o.
- In IDLE, write pattern 5,5,A,3 via cfg handshake; arm; stream 5,5,A,3 with gaps of 2 invalid cycles (timeout_i=0) -> one found_o. A cfg write attempted while ARMED sees cfg_ready_o=0.
- Assert arm_i and disarm_i together in ARMED, then mid-TRACK -> state_o=0 next cycle; no found_o from the subsequent 2,4.
- CNT_W=2, 5 consecutive matches -> match_cnt_o saturates at 3. With SEQ_DET_AUTO_DISARM_EN: state_o=0 after the first match; the second sequence is ignored until re-armed.
